// File: rtl/valu_pkg.sv
// Shared opcodes, element-width encodings and FSM states for the pipelined vector ALU.
package valu_pkg;

  localparam logic [3:0] OP_ADD_VV = 4'b0000;
  localparam logic [3:0] OP_ADD_VS = 4'b0001;
  localparam logic [3:0] OP_SUB_VV = 4'b0010;
  localparam logic [3:0] OP_SUB_VS = 4'b0011;
  localparam logic [3:0] OP_MUL_VV = 4'b0100;
  localparam logic [3:0] OP_MUL_VS = 4'b0101;
  localparam logic [3:0] OP_AND    = 4'b0110;
  localparam logic [3:0] OP_OR     = 4'b0111;
  localparam logic [3:0] OP_XOR    = 4'b1000;
  localparam logic [3:0] OP_REDSUM = 4'b1001;

  localparam logic [2:0] SEW_4  = 3'b000;
  localparam logic [2:0] SEW_8  = 3'b001;
  localparam logic [2:0] SEW_16 = 3'b010;
  localparam logic [2:0] SEW_32 = 3'b011;
  localparam logic [2:0] SEW_64 = 3'b100;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  function automatic int sew_width(input logic [2:0] sew);
    case (sew)
      SEW_4:   return 4;
      SEW_8:   return 8;
      SEW_16:  return 16;
      SEW_32:  return 32;
      SEW_64:  return 64;
      default: return 0;
    endcase
  endfunction

  // Low-SEW-bit mask; all-zero for an unsupported width.
  function automatic logic [63:0] sew_mask(input logic [2:0] sew);
    int w;
    w = sew_width(sew);
    return (w == 0) ? 64'd0 : ~(64'hFFFF_FFFF_FFFF_FFFE << (w - 1));
  endfunction

  function automatic logic op_supported(input logic [3:0] op);
    return op <= OP_REDSUM;
  endfunction

  function automatic logic sew_supported(input logic [2:0] sew);
    return sew <= SEW_64;
  endfunction

endpackage

// File: rtl/valu_lane.sv
// Combinational LANE_W-bit slice ALU: element-wise ops with mask/merge plus a slice partial sum.
module valu_lane
  import valu_pkg::*;
#(
  parameter int LANE_W = 64
) (
  input  logic [3:0]          op,
  input  logic [2:0]          sew,
  input  logic [LANE_W-1:0]   src1,
  input  logic [LANE_W-1:0]   src2,
  input  logic [63:0]         scalar,
  input  logic                mask_en,
  input  logic [LANE_W/4-1:0] lane_mask,
  input  logic [LANE_W-1:0]   old,
  output logic [LANE_W-1:0]   result,
  output logic [63:0]         part_sum
);

  // One element-wise datapath per legal SEW; the width mux below picks one.
  for (genvar k = 0; k < 5; k++) begin : g_sew
    localparam int EW = 4 << k;
    localparam int NE = LANE_W / EW;
    logic [LANE_W-1:0] res;
    logic [EW-1:0]     sum;

    always_comb begin
      logic [EW-1:0] x, y, r;
      logic          active;
      res = '0;
      sum = '0;
      for (int i = 0; i < NE; i++) begin
        x = src1[i*EW +: EW];
        y = (op == OP_ADD_VS || op == OP_SUB_VS || op == OP_MUL_VS) ?
            scalar[EW-1:0] : src2[i*EW +: EW];
        case (op)
          OP_ADD_VV, OP_ADD_VS: r = x + y;
          OP_SUB_VV, OP_SUB_VS: r = x - y;
          OP_MUL_VV, OP_MUL_VS: r = EW'($signed(x) * $signed(y));
          OP_AND:               r = x & y;
          OP_OR:                r = x | y;
          OP_XOR:               r = x ^ y;
          default:              r = '0;
        endcase
        active = !mask_en || lane_mask[i];
        res[i*EW +: EW] = active ? r : old[i*EW +: EW];
        if (active) sum = sum + x;
      end
    end
  end

  always_comb begin
    result   = '0;
    part_sum = '0;
    case (sew)
      SEW_4:   begin result = g_sew[0].res; part_sum = 64'(g_sew[0].sum); end
      SEW_8:   begin result = g_sew[1].res; part_sum = 64'(g_sew[1].sum); end
      SEW_16:  begin result = g_sew[2].res; part_sum = 64'(g_sew[2].sum); end
      SEW_32:  begin result = g_sew[3].res; part_sum = 64'(g_sew[3].sum); end
      SEW_64:  begin result = g_sew[4].res; part_sum = g_sew[4].sum; end
      default: ;
    endcase
  end

endmodule

// File: rtl/valu_pipe.sv
// Multi-cycle vector ALU: latches a request, runs NBEATS lane beats, then holds the result until taken.
module valu_pipe
  import valu_pkg::*;
#(
  parameter int VLEN   = 128,
  parameter int LANE_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        valu_op,
  input  logic [2:0]        SEW,
  input  logic [VLEN-1:0]   reg_in1,
  input  logic [VLEN-1:0]   reg_in2,
  input  logic [63:0]       reg_scalar_in,
  input  logic              mask_en,
  input  logic [VLEN/4-1:0] mask,
  input  logic [VLEN-1:0]   reg_old,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [VLEN-1:0]   reg_dest,
  output logic              op_err
);

  localparam int NBEATS = VLEN / LANE_W;
  localparam int CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int LMW    = LANE_W / 4;

  state_t              state, state_next;
  logic [CNT_W-1:0]    beat;
  logic [3:0]          op_q;
  logic [2:0]          sew_q;
  logic [VLEN-1:0]     in1_q, in2_q, old_q;
  logic [63:0]         scalar_q;
  logic                mask_en_q;
  logic [VLEN/4-1:0]   mask_q;
  logic [63:0]         acc;
  logic [VLEN-1:0]     dest;
  logic                err_q;
  logic [31:0]         elems;
  logic [LMW-1:0]      lane_mask;
  logic [LANE_W-1:0]   lane_res;
  logic [63:0]         lane_sum, acc_sum;
  logic                last_beat;

  assign last_beat = (beat == CNT_W'(NBEATS - 1));

  // Element indices advance by elements-per-beat, so the mask window depends on SEW.
  always_comb begin
    case (sew_q)
      SEW_4:   elems = 32'(LANE_W / 4);
      SEW_8:   elems = 32'(LANE_W / 8);
      SEW_16:  elems = 32'(LANE_W / 16);
      SEW_32:  elems = 32'(LANE_W / 32);
      SEW_64:  elems = 32'(LANE_W / 64);
      default: elems = 32'd0;
    endcase
    lane_mask = LMW'(mask_q >> (32'(beat) * elems));
    acc_sum   = (acc + lane_sum) & sew_mask(sew_q);
  end

  valu_lane #(.LANE_W(LANE_W)) u_lane (
    .op        (op_q),
    .sew       (sew_q),
    .src1      (in1_q[beat*LANE_W +: LANE_W]),
    .src2      (in2_q[beat*LANE_W +: LANE_W]),
    .scalar    (scalar_q),
    .mask_en   (mask_en_q),
    .lane_mask (lane_mask),
    .old       (old_q[beat*LANE_W +: LANE_W]),
    .result    (lane_res),
    .part_sum  (lane_sum)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = BUSY;
      end
      BUSY: if (last_beat) state_next = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Erroneous requests still walk the beats but never write the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat  <= '0;
      acc   <= '0;
      dest  <= '0;
      err_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          op_q      <= valu_op;
          sew_q     <= SEW;
          in1_q     <= reg_in1;
          in2_q     <= reg_in2;
          old_q     <= reg_old;
          scalar_q  <= reg_scalar_in;
          mask_en_q <= mask_en;
          mask_q    <= mask;
          beat      <= '0;
          acc       <= reg_scalar_in & sew_mask(SEW);
          dest      <= '0;
          err_q     <= !(op_supported(valu_op) && sew_supported(SEW));
        end
        BUSY: begin
          beat <= beat + 1'b1;
          acc  <= acc_sum;
          if (!err_q) begin
            if (op_q == OP_REDSUM) begin
              if (last_beat) dest <= VLEN'(acc_sum);
            end else begin
              dest[beat*LANE_W +: LANE_W] <= lane_res;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign reg_dest = dest;
  assign op_err   = err_q;

endmodule

// File: tb/tb_valu_pipe.sv
// Directed self-checking bench for valu_pipe: vector table plus reset, backpressure and abort sequences.
module tb_valu_pipe;

  localparam int VLEN   = 128;
  localparam int LANE_W = 64;
  localparam int NBEATS = VLEN / LANE_W;
  localparam int NVEC   = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        valu_op;
  logic [2:0]        sew;
  logic [VLEN-1:0]   reg_in1, reg_in2, reg_old, reg_dest;
  logic [63:0]       reg_scalar_in;
  logic              mask_en;
  logic [VLEN/4-1:0] mask;
  logic              out_valid, out_ready, op_err;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string        name;
    logic [3:0]   op;
    logic [2:0]   sew;
    logic [127:0] in1;
    logic [127:0] in2;
    logic [63:0]  scalar;
    logic         men;
    logic [31:0]  mask;
    logic [127:0] old;
    logic [127:0] exp_dest;
    logic         exp_err;
  } vec_t;

  vec_t vecs[NVEC];

  always #5 clk = ~clk;

  valu_pipe #(.VLEN(VLEN), .LANE_W(LANE_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .valu_op       (valu_op),
    .SEW           (sew),
    .reg_in1       (reg_in1),
    .reg_in2       (reg_in2),
    .reg_scalar_in (reg_scalar_in),
    .mask_en       (mask_en),
    .mask          (mask),
    .reg_old       (reg_old),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .reg_dest      (reg_dest),
    .op_err        (op_err)
  );

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h, wanted %h", name, act, exp);
    end
  endtask

  // Called 1ns after a rising edge; returns 1ns after the accepting edge.
  task automatic applyStimulus(input vec_t v);
    int waited = 0;
    valu_op       = v.op;
    sew           = v.sew;
    reg_in1       = v.in1;
    reg_in2       = v.in2;
    reg_scalar_in = v.scalar;
    mask_en       = v.men;
    mask          = v.mask;
    reg_old       = v.old;
    in_valid      = 1'b1;
    while (!in_ready && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    checkOutput({v.name, " in_ready before accept"}, 128'(in_ready), 128'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic waitResult(output int cyc);
    cyc = 1;
    while (!out_valid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic runVector(input vec_t v);
    int cyc;
    applyStimulus(v);
    waitResult(cyc);
    checkOutput({v.name, " latency"}, 128'(cyc), 128'(NBEATS + 1));
    checkOutput({v.name, " reg_dest"}, reg_dest, v.exp_dest);
    checkOutput({v.name, " op_err"}, 128'(op_err), 128'(v.exp_err));
    @(posedge clk); #1;
    checkOutput({v.name, " out_valid pulse"}, 128'(out_valid), 128'd0);
    checkOutput({v.name, " back to idle"}, 128'(in_ready), 128'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cyc;
    logic [127:0] held;

    vecs[0]  = '{"add8_vv", 4'h0, 3'd1, {16{8'hFF}}, {16{8'h02}}, 64'h0, 1'b0, 32'h0,
                 128'h0, {16{8'h01}}, 1'b0};
    vecs[1]  = '{"mul32_vs_masked", 4'h5, 3'd3, 128'h00000004_00000003_00000002_00000001, 128'h0,
                 64'h12345678_FFFFFFFF, 1'b1, 32'h5, {4{32'hAAAAAAAA}},
                 128'hAAAAAAAA_FFFFFFFD_AAAAAAAA_FFFFFFFF, 1'b0};
    vecs[2]  = '{"redsum16", 4'h9, 3'd2, {8{16'h4000}}, 128'h0, 64'h1, 1'b0, 32'h0,
                 {8{16'hBEEF}}, 128'h1, 1'b0};
    vecs[3]  = '{"redsum16_all_masked", 4'h9, 3'd2, {8{16'h4000}}, 128'h0, 64'h1, 1'b1, 32'h0,
                 {8{16'hBEEF}}, 128'h1, 1'b0};
    vecs[4]  = '{"sub4_vs", 4'h3, 3'd0, {32{4'h3}}, 128'h0, 64'hFFFF_FFFF_FFFF_FFF5, 1'b0, 32'h0,
                 128'h0, {32{4'hE}}, 1'b0};
    vecs[5]  = '{"and64_masked", 4'h6, 3'd4, 128'hFFFF0000FFFF0000_0F0F0F0F0F0F0F0F,
                 128'h00FF00FF00FF00FF_FFFFFFFF00000000, 64'h0, 1'b1, 32'hFFFFFFFE,
                 128'h1111111111111111_2222222222222222,
                 128'h00FF000000FF0000_2222222222222222, 1'b0};
    vecs[6]  = '{"xor16_vv", 4'h8, 3'd2, 128'h0123456789ABCDEF0123456789ABCDEF, {128{1'b1}},
                 64'h0, 1'b0, 32'h0, 128'h0, 128'hFEDCBA9876543210FEDCBA9876543210, 1'b0};
    vecs[7]  = '{"or8_masked", 4'h7, 3'd1, 128'h0, {16{8'h0F}}, 64'h0, 1'b1, 32'h00000FF0,
                 {16{8'h55}}, 128'h55555555_0F0F0F0F_0F0F0F0F_55555555, 1'b0};
    vecs[8]  = '{"sub32_vv", 4'h2, 3'd3, 128'h00000000_00000010_80000000_00000005,
                 128'h00000001_00000001_00000001_00000006, 64'h0, 1'b0, 32'h0, 128'h0,
                 128'hFFFFFFFF_0000000F_7FFFFFFF_FFFFFFFF, 1'b0};
    vecs[9]  = '{"mul8_vv", 4'h4, 3'd1, {16{8'hFE}}, {16{8'h03}}, 64'h0, 1'b0, 32'h0,
                 128'h0, {16{8'hFA}}, 1'b0};
    vecs[10] = '{"bad_op", 4'hF, 3'd1, {16{8'hFF}}, {16{8'h02}}, 64'h7, 1'b0, 32'h0,
                 {16{8'h33}}, 128'h0, 1'b1};
    vecs[11] = '{"bad_sew", 4'h0, 3'd5, {16{8'hFF}}, {16{8'h02}}, 64'h7, 1'b0, 32'h0,
                 {16{8'h33}}, 128'h0, 1'b1};
    vecs[12] = '{"redsum64_masked", 4'h9, 3'd4, 128'h0000000000000010_0000000000000005, 128'h0,
                 64'h100, 1'b1, 32'hFFFFFFFE, 128'h0, 128'h110, 1'b0};
    vecs[13] = '{"redsum4", 4'h9, 3'd0, {32{4'h1}}, 128'h0, 64'h2, 1'b0, 32'h0,
                 128'h0, 128'h2, 1'b0};
    vecs[14] = '{"redsum4_masked", 4'h9, 3'd0, {32{4'h1}}, 128'h0, 64'h2, 1'b1, 32'h80000003,
                 128'h0, 128'h5, 1'b0};
    vecs[15] = '{"add64_vs", 4'h1, 3'd4, 128'hFFFFFFFFFFFFFFFF_0000000000000001, 128'h0,
                 64'h1, 1'b0, 32'h0, 128'h0, 128'h0000000000000000_0000000000000002, 1'b0};

    // Reset held with a pending request: nothing may be accepted.
    rst = 1'b1;
    out_ready = 1'b1;
    valu_op = 4'h0; sew = 3'd1; reg_in1 = {16{8'hFF}}; reg_in2 = {16{8'h02}};
    reg_scalar_in = 64'h0; mask_en = 1'b0; mask = '0; reg_old = '0;
    in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      checkOutput("reset in_ready", 128'(in_ready), 128'd1);
      checkOutput("reset out_valid", 128'(out_valid), 128'd0);
      checkOutput("reset reg_dest", reg_dest, 128'h0);
      checkOutput("reset op_err", 128'(op_err), 128'd0);
    end
    rst = 1'b0;
    in_valid = 1'b0;
    @(posedge clk); #1;
    checkOutput("post-reset idle", 128'(in_ready), 128'd1);

    for (int i = 0; i < NVEC; i++) runVector(vecs[i]);

    // Backpressure: result must hold in DONE while a new request is refused.
    $display("[TB] backpressure sequence");
    out_ready = 1'b0;
    applyStimulus(vecs[0]);
    waitResult(cyc);
    checkOutput("bp latency", 128'(cyc), 128'(NBEATS + 1));
    checkOutput("bp reg_dest", reg_dest, vecs[0].exp_dest);
    held = vecs[0].exp_dest;
    reg_in1 = vecs[6].in1; reg_in2 = vecs[6].in2; valu_op = vecs[6].op; sew = vecs[6].sew;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checkOutput("bp out_valid held", 128'(out_valid), 128'd1);
      checkOutput("bp in_ready low", 128'(in_ready), 128'd0);
      checkOutput("bp reg_dest stable", reg_dest, held);
    end
    out_ready = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    checkOutput("bp release out_valid", 128'(out_valid), 128'd0);
    checkOutput("bp release in_ready", 128'(in_ready), 128'd1);
    @(posedge clk); #1;
    checkOutput("bp no stray accept", 128'(in_ready), 128'd1);

    // Abort: reset in the second BUSY cycle must swallow the operation.
    $display("[TB] abort sequence");
    applyStimulus(vecs[1]);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("abort in_ready", 128'(in_ready), 128'd1);
    checkOutput("abort reg_dest", reg_dest, 128'h0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      checkOutput("abort no out_valid", 128'(out_valid), 128'd0);
    end
    runVector(vecs[5]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/valu_pipe.md
Name: valu_pipe

Overview:
- Multi-cycle, parametrised successor to the single-cycle 64-bit vector ALU.
- Processes a VLEN-bit vector as LANE_W-bit beats through one shared lane datapath.
- Adds three things the single-cycle ALU lacks: valid/ready handshakes, per-element masking with merge, and a sum reduction.
- Sits between the vector register-file read stage and the writeback stage.

Parameters:
- VLEN, 128, vector register width in bits; must be a multiple of LANE_W.
- LANE_W, 64, bits processed per cycle; must be a power of two, at least 64.
- NBEATS, VLEN/LANE_W, derived value; not overridable.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept a request.
- valu_op  in  4  opcode, see Behaviour.
- SEW  in  3  element width: 000=4, 001=8, 010=16, 011=32, 100=64 bits.
- reg_in1  in  VLEN  vector operand 1.
- reg_in2  in  VLEN  vector operand 2.
- reg_scalar_in  in  64  scalar operand; low SEW bits used.
- mask_en  in  1  enables masking.
- mask  in  VLEN/4  bit i covers element i.
- reg_old  in  VLEN  prior destination value, used for merge.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- reg_dest  out  VLEN  result.
- op_err  out  1  unsupported opcode or SEW; qualified by out_valid.

Behaviour:
- Reset values: in_ready=1, out_valid=0, reg_dest=0, op_err=0. The FSM goes to IDLE and the beat counter and accumulator clear.
- rst mid-operation aborts the operation; no result is produced.
- FSM states are IDLE, BUSY and DONE.
- IDLE: in_ready=1. When in_valid is high, latch all inputs, clear the beat counter and go to BUSY.
- BUSY: in_ready=0. Each cycle processes beat b, which is bits [b*LANE_W +: LANE_W], and writes it into the result register. After beat NBEATS-1, go to DONE.
- DONE: out_valid=1. reg_dest and op_err stay stable while out_ready is low. When out_ready is high, go to IDLE; out_valid drops the next cycle.
- Latency: accept in cycle c gives out_valid high from cycle c+NBEATS+1. Throughput is at best one operation per NBEATS+2 cycles.
- Opcodes; all arithmetic wraps modulo 2^SEW per element with no carry between elements:
  - 0000 add vector-vector
  - 0001 add vector-scalar
  - 0010 sub vector-vector
  - 0011 sub vector-scalar
  - 0100 mul vector-vector, signed, low SEW bits kept
  - 0101 mul vector-scalar, signed, low SEW bits kept
  - 0110 and
  - 0111 or
  - 1000 xor
  - 1001 reduction sum (new)
- Masking, for opcodes 0000-1000 with mask_en=1: element i with mask[i]=0 takes reg_old's element i. Logic ops apply the mask at SEW element granularity. With mask_en=0, every element is computed.
- Reduction sum: acc = reg_scalar_in[SEW-1:0] + sum of active elements of reg_in1, mod 2^SEW.
  - acc is accumulated over the beats.
  - reg_dest[SEW-1:0]=acc; all other bits of reg_dest are 0.
  - Masked-off elements are excluded from the sum.
  - With every element masked off, the result is the scalar operand alone.
- SEW=100 with 4-bit mask granularity: element i uses mask[i] for i < VLEN/64; higher mask bits are ignored.
- Unsupported op (1010-1111) or SEW 101-111: the FSM still runs its full timing, reg_dest=0 and op_err=1.
- in_valid while in BUSY or DONE is ignored, because in_ready=0; the upstream stage holds the request.

Decomposition:
- Package valu_pkg holds:
  - opcode localparams OP_ADD_VV through OP_REDSUM
  - SEW encodings and an SEW-to-bit-width function
  - FSM state encoding
- One sub-module, valu_lane: a combinational LANE_W-bit slice ALU.
  - Inputs: op, SEW, two operands, scalar, lane mask bits, reg_old slice.
  - Outputs: result slice and the partial reduction sum of the slice.
  - valu_pipe instantiates it once and supplies the FSM, beat counter, operand registers, accumulator and handshake.

Test Plan:
- Reset: hold rst for 2 cycles with in_valid=1 -> in_ready=1, out_valid=0, reg_dest=0 throughout; no request accepted.
- Latency and add (VLEN=128, LANE_W=64): SEW=001, op 0000, reg_in1 all 8'hFF, reg_in2 all 8'h02, out_ready=1 -> all bytes 8'h01 (no inter-element carry). out_valid rises exactly 3 cycles after accept and is high for 1 cycle.
- Masked mul: SEW=011, op 0101, scalar 32'hFFFFFFFF (-1), reg_in1 elements {4,3,2,1}, mask=...0101, reg_old all 32'hAAAAAAAA -> elements {AAAAAAAA, FFFFFFFD, AAAAAAAA, FFFFFFFF}.
- Reduction: SEW=010, op 1001, eight 16-bit elements of 16'h4000, scalar 16'h0001, mask_en=0 -> reg_dest=128'h0001. Repeat with mask_en=1 and mask=0 -> reg_dest=128'h0001.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> reg_dest stable, in_ready=0, a new in_valid is not accepted. Releasing out_ready -> IDLE next cycle.
- Error and abort: op 1111 -> op_err=1, reg_dest=0, normal latency. Then assert rst in the 2nd BUSY cycle of a valid operation -> out_valid never rises and in_ready=1 after reset.
